zzecc_sctag_dec39_pipe: RTL

ZZECC_SCTAG_DEC39_PIPE -- requirements
Module: zzecc_sctag_dec39_pipe

---
 rtl/zzecc_sctag_dec39_pipe_pkg.sv | 73 +++++++
 rtl/zzecc_sctag_dec39_pipe_if.sv | 37 +++
 rtl/zzecc_sctag_syn39.sv | 25 ++
 rtl/zzecc_sctag_dec39_pipe.sv | 129 ++++++++++++
 4 files changed

// File: rtl/zzecc_sctag_dec39_pipe_pkg.sv
// Shared definitions for the 39-bit SEC-DED decoder (32 data + 6 Hamming + 1 overall).
// The RTL and the code-table generator both use this package.
// Contents:
//   - codeword widths
//   - data-bit -> codeword-position map (DataPos)
//   - per-check-bit data masks (ChkMask)
//   - syndrome class encoding and the classification helper
package zzecc_sctag_dec39_pipe_pkg;

    localparam int unsigned DataW  = 32;
    localparam int unsigned ChkW   = 6;
    localparam int unsigned SynW   = ChkW + 1;
    localparam int unsigned MaxPos = 38;

    typedef enum logic [1:0] {
        SynNe = 2'd0,
        SynCe = 2'd1,
        SynUe = 2'd2
    } syn_class_e;

    // Position of data bit idx.
    // Data fills the positions 3..38 that are not powers of two, in ascending order.
    function automatic logic [5:0] data_pos(input int idx);
        int         k;
        logic [5:0] pos;
        k   = 0;
        pos = '0;
        for (int p = 1; p <= int'(MaxPos); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k == idx) pos = 6'(p);
                k++;
            end
        end
        return pos;
    endfunction

    function automatic logic [DataW-1:0][5:0] gen_data_pos();
        logic [DataW-1:0][5:0] m;
        for (int i = 0; i < int'(DataW); i++) m[i] = data_pos(i);
        return m;
    endfunction

    // Check bit j covers every data bit whose position has bit j set.
    function automatic logic [ChkW-1:0][DataW-1:0] gen_chk_masks();
        logic [ChkW-1:0][DataW-1:0] m;
        logic [5:0]                 pos;
        m = '0;
        for (int i = 0; i < int'(DataW); i++) begin
            pos = data_pos(i);
            for (int j = 0; j < int'(ChkW); j++) m[j][i] = pos[j];
        end
        return m;
    endfunction

    localparam logic [DataW-1:0][5:0]     DataPos = gen_data_pos();
    localparam logic [ChkW-1:0][DataW-1:0] ChkMask = gen_chk_masks();

    // syn = {overall, s[5:0]}.
    // An odd overall parity with s beyond the last codeword position
    // cannot be a single-bit error.
    function automatic syn_class_e syn_classify(input logic [SynW-1:0] syn);
        syn_class_e cls;
        if (!syn[ChkW]) begin
            cls = (syn[ChkW-1:0] == '0) ? SynNe : SynUe;
        end else if (syn[ChkW-1:0] > 6'(MaxPos)) begin
            cls = SynUe;
        end else begin
            cls = SynCe;
        end
        return cls;
    endfunction

endpackage

// File: rtl/zzecc_sctag_dec39_pipe_if.sv
// Handshake and data bundle for zzecc_sctag_dec39_pipe.
// Signals:
//   in_vld/in_rdy, din, parity                  input word handshake
//   out_vld/out_rdy, dout, ne/ce/ue, syndrome   result handshake
//   cnt_clr, ce_cnt, ue_cnt                     error counters
// Modports:
//   master   the producer/consumer side
//   slave    the decoder side
interface zzecc_sctag_dec39_pipe_if;
    import zzecc_sctag_dec39_pipe_pkg::*;

    logic             in_vld;
    logic             in_rdy;
    logic [DataW-1:0] din;
    logic [SynW-1:0]  parity;
    logic             out_vld;
    logic             out_rdy;
    logic [DataW-1:0] dout;
    logic             ne;
    logic             ce;
    logic             ue;
    logic [SynW-1:0]  syndrome;
    logic             cnt_clr;
    logic [15:0]      ce_cnt;
    logic [15:0]      ue_cnt;

    modport master (
        output in_vld, din, parity, out_rdy, cnt_clr,
        input  in_rdy, out_vld, dout, ne, ce, ue, syndrome, ce_cnt, ue_cnt
    );

    modport slave (
        input  in_vld, din, parity, out_rdy, cnt_clr,
        output in_rdy, out_vld, dout, ne, ce, ue, syndrome, ce_cnt, ue_cnt
    );

endinterface

// File: rtl/zzecc_sctag_syn39.sv
// Combinational syndrome generator for the 39-bit SEC-DED code.
// Ports:
//   din_i     received data d0..d31
//   parity_i  received check bits; [5:0] = P1..P32, [6] = overall parity
//   syn_o     {overall, s[5:0]}
//             s is the recomputed check bits XOR the received check bits;
//             overall is the XOR of every received bit.
module zzecc_sctag_syn39
    import zzecc_sctag_dec39_pipe_pkg::*;
(
    input  logic [DataW-1:0] din_i,
    input  logic [SynW-1:0]  parity_i,
    output logic [SynW-1:0]  syn_o
);

    logic [ChkW-1:0] chk;

    always_comb begin
        chk = '0;
        for (int j = 0; j < int'(ChkW); j++) chk[j] = ^(din_i & ChkMask[j]);
    end

    assign syn_o = {(^din_i) ^ (^parity_i), chk ^ parity_i[ChkW-1:0]};

endmodule

// File: rtl/zzecc_sctag_dec39_pipe.sv
// Two-stage pipelined SEC-DED decoder for 32 data bits plus 7 check bits.
// Stage 1 registers the word and its syndrome.
// Stage 2 registers the corrected data, the flags and the syndrome.
// Both stages hold while the output is stalled.
// Ports:
//   rclk     clock, rising edge
//   reset    synchronous, active-high
//   bus_io   zzecc_sctag_dec39_pipe_if.slave; handshakes, data, flags, counters
// Build option:
//   ZZECC_DEC39_ERR_CNT_EN  adds the saturating ce/ue counters.
//                           Without it, ce_cnt/ue_cnt read 0 and cnt_clr is ignored.
module zzecc_sctag_dec39_pipe
    import zzecc_sctag_dec39_pipe_pkg::*;
(
    input logic                     rclk,
    input logic                     reset,
    zzecc_sctag_dec39_pipe_if.slave bus_io
);

    logic             s1_vld_q;
    logic [DataW-1:0] s1_din_q;
    logic [SynW-1:0]  s1_syn_q;
    logic             out_vld_q;
    logic [DataW-1:0] dout_q;
    logic [SynW-1:0]  syn_q;
    logic             ne_q;
    logic             ce_q;
    logic             ue_q;

    logic             out_vld;
    logic             stall;
    logic             in_rdy;
    logic [SynW-1:0]  syn_calc;
    syn_class_e       cls;
    logic [DataW-1:0] flip_mask;
    logic [DataW-1:0] dout_d;

    // Gating with reset guarantees no output transfer in a reset cycle.
    assign out_vld = out_vld_q & ~reset;
    assign stall   = out_vld & ~bus_io.out_rdy;
    assign in_rdy  = ~reset & (~s1_vld_q | ~stall);

    zzecc_sctag_syn39 u_syn (
        .din_i    (bus_io.din),
        .parity_i (bus_io.parity),
        .syn_o    (syn_calc)
    );

    // Correction mux.
    // flip_mask is non-zero only when s names a data position.
    // A check-bit error therefore leaves the data unchanged.
    always_comb begin
        cls       = syn_classify(s1_syn_q);
        flip_mask = '0;
        for (int i = 0; i < int'(DataW); i++) begin
            if (s1_syn_q[ChkW-1:0] == DataPos[i]) flip_mask[i] = 1'b1;
        end
        dout_d = (cls == SynCe) ? (s1_din_q ^ flip_mask) : s1_din_q;
    end

    // Stage 1 loads whenever it can hand its word on or is empty.
    always_ff @(posedge rclk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_din_q <= '0;
            s1_syn_q <= '0;
        end else if (in_rdy) begin
            s1_vld_q <= bus_io.in_vld;
            if (bus_io.in_vld) begin
                s1_din_q <= bus_io.din;
                s1_syn_q <= syn_calc;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            syn_q     <= '0;
            ne_q      <= 1'b1;
            ce_q      <= 1'b0;
            ue_q      <= 1'b0;
        end else if (!stall) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                dout_q <= dout_d;
                syn_q  <= s1_syn_q;
                ne_q   <= (cls == SynNe);
                ce_q   <= (cls == SynCe);
                ue_q   <= (cls == SynUe);
            end
        end
    end

    assign bus_io.in_rdy   = in_rdy;
    assign bus_io.out_vld  = out_vld;
    assign bus_io.dout     = dout_q;
    assign bus_io.syndrome = syn_q;
    assign bus_io.ne       = ne_q;
    assign bus_io.ce       = ce_q;
    assign bus_io.ue       = ue_q;

`ifdef ZZECC_DEC39_ERR_CNT_EN
    logic        out_xfer;
    logic [15:0] ce_cnt_q;
    logic [15:0] ue_cnt_q;

    assign out_xfer = out_vld & bus_io.out_rdy;

    // Clear wins over a same-cycle increment; both counters saturate.
    always_ff @(posedge rclk) begin
        if (reset || bus_io.cnt_clr) begin
            ce_cnt_q <= '0;
            ue_cnt_q <= '0;
        end else if (out_xfer) begin
            if (ce_q && (ce_cnt_q != 16'hFFFF)) ce_cnt_q <= ce_cnt_q + 16'd1;
            if (ue_q && (ue_cnt_q != 16'hFFFF)) ue_cnt_q <= ue_cnt_q + 16'd1;
        end
    end

    assign bus_io.ce_cnt = ce_cnt_q;
    assign bus_io.ue_cnt = ue_cnt_q;
`else
    assign bus_io.ce_cnt = '0;
    assign bus_io.ue_cnt = '0;
`endif

endmodule
